uart_tx_param: RTL and testbench
================================

// Module: uart_tx_param
// PURPOSE
//  Parametrised UART transmitter: next generation of the fixed 8N1 TX.
//  Configurable data width, parity, stop bits and baud divisor.
//  Provides a valid/ready byte input and a one-cycle tx_done pulse.
//  Drives RS-485 direction (dir) with a configurable post-frame hold.
//  Sits between the protocol/command layer and the board TX pin / RS-485 transceiver.
// PARAMETERS
//  CLK_FREQ    50000000  system clock frequency, Hz
//  BAUD_RATE   9600      line rate; BAUD_DIV = CLK_FREQ/BAUD_RATE (truncated), must be >= 4
//  DATA_BITS   8         data bits per frame, 5..9, LSB first
//  PARITY      0         0 = none, 1 = odd, 2 = even
//  STOP_BITS   1         1 or 2
//  DIR_HOLD    1         whole bit periods dir stays high after the last stop bit, 0..3
// PORTS
//  clk       in   1          system clock
//  rst_n     in   1          asynchronous active-low reset
//  valid     in   1          pi_data is valid; transfer occurs when valid && ready at posedge clk
//  pi_data   in   DATA_BITS  word to send; sampled only on the accept cycle
//  ready     out  1          block can accept a word
//  busy      out  1          frame or dir hold in progress
//  tx        out  1          serial line, idle high
//  tx_done   out  1          one-cycle pulse at end of the last stop bit
//  dir       out  1          RS-485 driver enable, high while driving
// BEHAVIOUR
//  Reset (async): tx=1, ready=1, busy=0, tx_done=0, dir=0, state IDLE, counters 0.
//   Reset mid-frame aborts immediately. No partial frame resumes after release.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> [HOLD] -> IDLE.
//   PARITY is skipped when PARITY==0. HOLD is skipped when DIR_HOLD==0.
//  Accept: at edge k with valid&&ready, latch pi_data and precompute the parity bit.
//   From edge k: ready=0, busy=1, dir=1, tx=0 (start bit). All outputs are registered.
//  Bit timing: every bit (start, data, parity, stop) lasts exactly BAUD_DIV clocks.
//   Baud counter restarts on accept, so there is no phase carry-over between frames.
//  Data: bit i is sent in slot i+1, LSB first. Only DATA_BITS bits are sent.
//  Parity: odd sets the parity bit so the total count of ones (data + parity) is odd.
//   Even sets it so that total is even.
//  Stop: tx=1 for STOP_BITS*BAUD_DIV clocks.
//  End of the last stop period: tx_done=1 for exactly one cycle and ready=1 in the same cycle.
//   If DIR_HOLD==0: dir=0 and busy=0 in that same cycle.
//   Else: state HOLD for DIR_HOLD*BAUD_DIV clocks with tx=1 and dir=1, then dir=0 and busy=0.
//   ready is already 1 during HOLD.
//  Back-to-back: accept is allowed on the tx_done cycle or during HOLD.
//   HOLD is abandoned, dir stays 1, and the next start bit begins at the next edge (no idle gap).
//  valid while ready=0 is ignored, with no queuing. pi_data changes after accept have no effect.
//  Frame length (clocks) = BAUD_DIV*(1+DATA_BITS+(PARITY!=0)+STOP_BITS).
//  Counter widths: baud counter $clog2(BAUD_DIV); bit counter 4 bits.
//   No width overflow occurs for any legal parameter set.
//  Illegal parameters (DATA_BITS out of range, PARITY>2, STOP_BITS not 1/2,
//   BAUD_DIV<4, DIR_HOLD>3) are rejected at elaboration with $error.
// STRUCTURE
//  uart_pkg.vh provides:
//   - state encodings IDLE/START/DATA/PARITY/STOP/HOLD
//   - parity codes PAR_NONE/PAR_ODD/PAR_EVEN
//   - the BAUD_DIV calculation and the clog2 helper
//   It is shared with the future parametrised RX.
//  Sub-module uart_baud_tick: counter with clear input.
//   Emits a one-cycle tick every BAUD_DIV clocks. Reused by the RX.
//  FSM, shift register, parity and dir logic stay in uart_tx_param.
// TESTING (CLK_FREQ=1000, BAUD_RATE=100 -> BAUD_DIV=10 unless stated)
//  8N1, send 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1, each 10 clocks.
//   tx_done at clock 100 after accept; ready low for exactly 100 clocks.
//  PARITY=1, send 0x01 -> parity bit 0. PARITY=2, send 0x07 -> parity bit 1.
//   Frame length 110 clocks.
//  DATA_BITS=7, STOP_BITS=2, send 0x7F -> 7 ones then 20 clocks of stop.
//   tx_done at clock 100.
//  Back-to-back: valid held high with 0x55 then 0xAA.
//   Second start bit begins the clock after tx_done; tx has no idle-high gap.
//  DIR_HOLD=2: dir falls 20 clocks after tx_done.
//   valid pulsed mid-frame with ready=0 is ignored: exactly one frame is sent.
//  rst_n asserted at clock 45 of a frame -> tx=1, ready=1, dir=0 immediately.
//   After release, a new 0x3C sends cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg
//  Shared definitions for the parametrised UART transmitter and the
//  future parametrised receiver.
//  - uart_state_t : frame FSM state encodings
//  - PAR_*        : parity mode codes
//  - uart_baud_div: clocks per bit from clock frequency and line rate
//  - uart_clog2   : ceil(log2(value)) usable in constant expressions
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_HOLD
    } uart_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Truncating division: the bit period is rounded down to whole clocks.
    function automatic int uart_baud_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int uart_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
//  Bit-period timer. Counts 0..BAUD_DIV-1 and flags the last count, so
//  tick is high for one cycle out of every BAUD_DIV. clr restarts the
//  period so a new frame never inherits phase from the previous one.
// Ports
//  clk    in  1  system clock
//  rst_n  in  1  asynchronous active-low reset
//  clr    in  1  restart the bit period (counter to 0 at the next edge)
//  tick   out 1  high during the last clock of each bit period
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = uart_clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr || (cnt_reg == CNT_LAST)) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param
//  Parametrised UART transmitter with RS-485 direction control.
//  Frame: start, DATA_BITS data (LSB first), optional parity, STOP_BITS
//  stop bits, then an optional DIR_HOLD bit-period window with dir held.
//  Every output is registered.
// Ports
//  clk      in  1          system clock
//  rst_n    in  1          asynchronous active-low reset
//  valid    in  1          pi_data valid; accepted when valid && ready
//  pi_data  in  DATA_BITS  word to send, sampled on the accept cycle
//  ready    out 1          can accept a word (also during tx_done / hold)
//  busy     out 1          frame or dir hold in progress
//  tx       out 1          serial line, idle high
//  tx_done  out 1          one-cycle pulse at the end of the last stop bit
//  dir      out 1          RS-485 driver enable
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD_RATE = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1,
    parameter int DIR_HOLD  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] pi_data,
    output logic                 ready,
    output logic                 busy,
    output logic                 tx,
    output logic                 tx_done,
    output logic                 dir
);

    localparam int BAUD_DIV = uart_baud_div(CLK_FREQ, BAUD_RATE);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (BAUD_DIV < 4) begin : g_bad_baud_div
        $error("uart_tx_param: CLK_FREQ/BAUD_RATE must be >= 4");
    end
    if (DIR_HOLD < 0 || DIR_HOLD > 3) begin : g_bad_dir_hold
        $error("uart_tx_param: DIR_HOLD must be 0..3");
    end

    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic [3:0] LAST_HOLD = 4'(DIR_HOLD - 1);

    uart_state_t          state_reg, state_next;
    logic [DATA_BITS-1:0] shift_reg, shift_next;
    logic [3:0]           bit_cnt_reg, bit_cnt_next;
    logic                 par_reg, par_next;
    logic                 tx_reg, tx_next;
    logic                 ready_reg, ready_next;
    logic                 busy_reg, busy_next;
    logic                 dir_reg, dir_next;
    logic                 done_reg, done_next;
    logic                 accept;
    logic                 tick;

    // ready is registered, so an accept can only happen in IDLE, on the
    // tx_done cycle or during HOLD; it always wins over the running state.
    assign accept = valid && ready_reg;

    uart_baud_tick #(
        .BAUD_DIV(BAUD_DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (accept),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            shift_reg   <= '0;
            bit_cnt_reg <= '0;
            par_reg     <= 1'b0;
            tx_reg      <= 1'b1;
            ready_reg   <= 1'b1;
            busy_reg    <= 1'b0;
            dir_reg     <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
            par_reg     <= par_next;
            tx_reg      <= tx_next;
            ready_reg   <= ready_next;
            busy_reg    <= busy_next;
            dir_reg     <= dir_next;
            done_reg    <= done_next;
        end
    end

    // Next-state logic computes the value each output takes for the bit
    // period that starts at the coming edge.
    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        par_next     = par_reg;
        tx_next      = tx_reg;
        ready_next   = ready_reg;
        busy_next    = busy_reg;
        dir_next     = dir_reg;
        done_next    = 1'b0;

        if (accept) begin
            state_next   = ST_START;
            shift_next   = pi_data;
            bit_cnt_next = '0;
            par_next     = (PARITY == PAR_ODD) ? ~(^pi_data) : (^pi_data);
            tx_next      = 1'b0;
            ready_next   = 1'b0;
            busy_next    = 1'b1;
            dir_next     = 1'b1;
        end else if (tick) begin
            case (state_reg)
                ST_START: begin
                    state_next   = ST_DATA;
                    tx_next      = shift_reg[0];
                    shift_next   = shift_reg >> 1;
                    bit_cnt_next = '0;
                end
                ST_DATA: begin
                    if (bit_cnt_reg == LAST_DATA) begin
                        bit_cnt_next = '0;
                        if (PARITY != PAR_NONE) begin
                            state_next = ST_PARITY;
                            tx_next    = par_reg;
                        end else begin
                            state_next = ST_STOP;
                            tx_next    = 1'b1;
                        end
                    end else begin
                        tx_next      = shift_reg[0];
                        shift_next   = shift_reg >> 1;
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
                ST_PARITY: begin
                    state_next   = ST_STOP;
                    tx_next      = 1'b1;
                    bit_cnt_next = '0;
                end
                ST_STOP: begin
                    if (bit_cnt_reg == LAST_STOP) begin
                        done_next    = 1'b1;
                        ready_next   = 1'b1;
                        bit_cnt_next = '0;
                        if (DIR_HOLD == 0) begin
                            state_next = ST_IDLE;
                            busy_next  = 1'b0;
                            dir_next   = 1'b0;
                        end else begin
                            state_next = ST_HOLD;
                        end
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
                ST_HOLD: begin
                    if (bit_cnt_reg == LAST_HOLD) begin
                        state_next   = ST_IDLE;
                        bit_cnt_next = '0;
                        busy_next    = 1'b0;
                        dir_next     = 1'b0;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
                ST_IDLE: begin
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign tx      = tx_reg;
    assign ready   = ready_reg;
    assign busy    = busy_reg;
    assign dir     = dir_reg;
    assign tx_done = done_reg;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb_uart_tx_param
//  Five transmitter instances with different frame formats share clk and
//  rst_n. Each directed frame is given as the expected line sequence in
//  transmission order ('0'/'1' per bit, start bit first, stop bits last),
//  written out by hand from the word being sent.
module tb_uart_tx_param;

    localparam int BD = 10;   // 1000 Hz / 100 baud

    //                           inst: 0  1  2  3  4
    localparam int P_DB  [5] = '{8, 8, 8, 7, 8};
    localparam int P_PAR [5] = '{0, 1, 2, 0, 0};
    localparam int P_STOP[5] = '{1, 1, 1, 2, 1};
    localparam int P_HOLD[5] = '{0, 1, 1, 1, 2};

    logic       clk;
    logic       rst_n;
    logic [4:0] valid_s;
    logic [8:0] data_s [5];
    logic [4:0] ready_s;
    logic [4:0] busy_s;
    logic [4:0] tx_s;
    logic [4:0] done_s;
    logic [4:0] dir_s;

    int checks;
    int errors;

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_dut
            localparam int DB = P_DB[gi];
            uart_tx_param #(
                .CLK_FREQ (1000),
                .BAUD_RATE(100),
                .DATA_BITS(DB),
                .PARITY   (P_PAR[gi]),
                .STOP_BITS(P_STOP[gi]),
                .DIR_HOLD (P_HOLD[gi])
            ) u_dut (
                .clk    (clk),
                .rst_n  (rst_n),
                .valid  (valid_s[gi]),
                .pi_data(data_s[gi][DB-1:0]),
                .ready  (ready_s[gi]),
                .busy   (busy_s[gi]),
                .tx     (tx_s[gi]),
                .tx_done(done_s[gi]),
                .dir    (dir_s[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at the falling edge just after the accept edge (c = 0).
    // Checks both ends of every bit, the tx_done edge and ready release,
    // and returns at the falling edge inside the tx_done cycle (c = L).
    // pulse_at >= 0 raises valid for one clock at that offset with junk data.
    task automatic check_frame(input int id, input string seq, input int pulse_at, input string tag);
        int len;
        int l;
        logic exp_bit;
        len = seq.len();
        l   = len * BD;
        for (int c = 0; c <= l; c++) begin
            if (c > 0) @(negedge clk);
            if (pulse_at >= 0) begin
                if (c == pulse_at) begin
                    valid_s[id] = 1'b1;
                    data_s[id]  = 9'h1FF;
                end else if (c == pulse_at + 1) begin
                    valid_s[id] = 1'b0;
                end
            end
            if (c == 0) begin
                check($sformatf("%s_ready_low", tag), 32'(ready_s[id]), 32'd0);
                check($sformatf("%s_busy_high", tag), 32'(busy_s[id]), 32'd1);
                check($sformatf("%s_dir_high", tag), 32'(dir_s[id]), 32'd1);
            end
            if (c < l) begin
                // 8'd49 is the character '1'
                exp_bit = (seq.getc(c / BD) == 8'd49);
                if ((c % BD == 0) || (c % BD == BD - 1))
                    check($sformatf("%s_bit%0d_c%0d", tag, c / BD, c), 32'(tx_s[id]), 32'(exp_bit));
            end
            if (c == l - 1) begin
                check($sformatf("%s_done_early", tag), 32'(done_s[id]), 32'd0);
                check($sformatf("%s_ready_early", tag), 32'(ready_s[id]), 32'd0);
            end
            if (c == l) begin
                check($sformatf("%s_done", tag), 32'(done_s[id]), 32'd1);
                check($sformatf("%s_ready_back", tag), 32'(ready_s[id]), 32'd1);
                check($sformatf("%s_tx_idle", tag), 32'(tx_s[id]), 32'd1);
            end
        end
        $display("frame inst=%0d tag=%s bits=%s clocks=%0d", id, tag, seq, l);
    endtask

    task automatic frame_check(input int id, input logic [8:0] word, input string seq, input string tag);
        @(negedge clk);
        valid_s[id] = 1'b1;
        data_s[id]  = word;
        @(negedge clk);
        valid_s[id] = 1'b0;
        data_s[id]  = ~word;   // must not disturb the frame in flight
        check_frame(id, seq, -1, tag);
    endtask

    initial begin
        int tx_low;
        checks  = 0;
        errors  = 0;
        rst_n   = 1'b0;
        valid_s = '0;
        for (int i = 0; i < 5; i++) data_s[i] = '0;

        #12;
        check("rst_tx", 32'(tx_s), 32'h1F);
        check("rst_ready", 32'(ready_s), 32'h1F);
        check("rst_busy", 32'(busy_s), 32'h00);
        check("rst_done", 32'(done_s), 32'h00);
        check("rst_dir", 32'(dir_s), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 8N1 0xA5, no dir hold
        frame_check(0, 9'h0A5, "0101001011", "a5");
        check("a5_dir_off", 32'(dir_s[0]), 32'd0);
        check("a5_busy_off", 32'(busy_s[0]), 32'd0);
        @(negedge clk);
        check("a5_done_pulse", 32'(done_s[0]), 32'd0);

        // 8O1 0x01 -> parity 0, then one bit period of dir hold
        frame_check(1, 9'h001, "01000000001", "odd");
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j == 9)  check("odd_dir_hold", 32'(dir_s[1]), 32'd1);
            if (j == 10) check("odd_dir_off", 32'(dir_s[1]), 32'd0);
        end

        // 8E1 0x07 -> parity 1
        frame_check(2, 9'h007, "01110000011", "even");
        repeat (12) @(negedge clk);

        // 7N2 0x7F -> 7 ones, 20 clocks of stop
        frame_check(3, 9'h07F, "0111111111", "d7s2");
        repeat (12) @(negedge clk);

        // DIR_HOLD=2 with an ignored mid-frame valid pulse
        @(negedge clk);
        valid_s[4] = 1'b1;
        data_s[4]  = 9'h096;
        @(negedge clk);
        valid_s[4] = 1'b0;
        check_frame(4, "0011010011", 45, "hold");
        check("hold_dir_at_done", 32'(dir_s[4]), 32'd1);
        tx_low = 0;
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            if (tx_s[4] == 1'b0) tx_low++;
            if (j == 1) check("hold_done_pulse", 32'(done_s[4]), 32'd0);
            if (j == 19) begin
                check("hold_dir_19", 32'(dir_s[4]), 32'd1);
                check("hold_busy_19", 32'(busy_s[4]), 32'd1);
                check("hold_ready_19", 32'(ready_s[4]), 32'd1);
            end
            if (j == 20) begin
                check("hold_dir_20", 32'(dir_s[4]), 32'd0);
                check("hold_busy_20", 32'(busy_s[4]), 32'd0);
            end
        end
        check("hold_no_second_frame", 32'(tx_low), 32'd0);

        // Back-to-back 0x55 then 0xAA with valid held high; HOLD is abandoned
        @(negedge clk);
        valid_s[4] = 1'b1;
        data_s[4]  = 9'h055;
        @(negedge clk);
        data_s[4]  = 9'h0AA;
        check_frame(4, "0101010101", -1, "b2b1");
        check("b2b_dir_kept", 32'(dir_s[4]), 32'd1);
        @(negedge clk);
        valid_s[4] = 1'b0;
        check_frame(4, "0010101011", -1, "b2b2");
        repeat (25) @(negedge clk);

        // Reset 45 clocks into a frame, then a clean 0x3C
        @(negedge clk);
        valid_s[0] = 1'b1;
        data_s[0]  = 9'h0A5;
        @(negedge clk);
        valid_s[0] = 1'b0;
        repeat (45) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_tx", 32'(tx_s[0]), 32'd1);
        check("abort_ready", 32'(ready_s[0]), 32'd1);
        check("abort_dir", 32'(dir_s[0]), 32'd0);
        check("abort_busy", 32'(busy_s[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_low = 0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            if (tx_s[0] == 1'b0) tx_low++;
        end
        check("abort_no_resume", 32'(tx_low), 32'd0);
        frame_check(0, 9'h03C, "0001111001", "3c");
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
